rom_raster_scanner: RTL and testbench

// - Address-generation and pixel-capture stage directly upstream of Memory_ROM.
// - On start, sweeps yoff/xoff row-major over one stored image selected by img_sel,

---
 rtl/rom_raster_scanner_if.sv | 22 ++
 rtl/rom_raster_scanner.sv | 195 +++++++++++++++++++
 tb/tb_rom_raster_scanner.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_raster_scanner_if.sv
// Pixel stream bundle (valid/ready plus coordinates) from the raster scanner
// to the histogram-equalization datapath.
interface rom_raster_scanner_if #(
  parameter int ADDR_W = 8
);
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_data;
  logic [ADDR_W-1:0] pix_x;
  logic [ADDR_W-1:0] pix_y;
  logic              pix_last;

  modport master (
    output pix_valid, pix_data, pix_x, pix_y, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_x, pix_y, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/rom_raster_scanner.sv
// Sweeps one Memory_ROM image row-major and streams each 1-bit pixel with its coordinates.
// Optional PIXEL_COUNT_EN adds ones_count: number of accepted beats carrying a 1.
module rom_raster_scanner #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           img_sel,
  output logic [ADDR_W-1:0]    xoff,
  output logic [ADDR_W-1:0]    yoff,
  output logic [2:0]           memorySelect,
  input  logic                 pixel,
  rom_raster_scanner_if.master pix,
  output logic                 busy,
  output logic                 done
`ifdef PIXEL_COUNT_EN
  ,
  output logic [2*ADDR_W:0]    ones_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] X_MAX  = ADDR_W'(IMG_W - 32'sd1);
  localparam logic [ADDR_W-1:0] Y_MAX  = ADDR_W'(IMG_H - 32'sd1);
  localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] xoff_r, xoff_nxt_s, yoff_r, yoff_nxt_s;
  logic [2:0]        msel_r, msel_nxt_s;
  logic              valid_r, valid_nxt_s, data_r, data_nxt_s, last_r, last_nxt_s;
  logic [ADDR_W-1:0] x_r, x_nxt_s, y_r, y_nxt_s;
  logic              busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic              advance_s, at_last_s, accept_s;

  assign advance_s = !valid_r || pix.pix_ready;
  assign at_last_s = (xoff_r == X_MAX) && (yoff_r == Y_MAX);
  assign accept_s  = valid_r && pix.pix_ready;

  // Next-state and next-register values; a stalled beat keeps everything frozen.
  always_comb begin
    state_nxt_s = state_r;
    xoff_nxt_s  = xoff_r;
    yoff_nxt_s  = yoff_r;
    msel_nxt_s  = msel_r;
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    last_nxt_s  = last_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SCAN;
          msel_nxt_s  = img_sel;
          xoff_nxt_s  = A_ZERO;
          yoff_nxt_s  = A_ZERO;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (advance_s) begin
          data_nxt_s  = pixel;
          x_nxt_s     = xoff_r;
          y_nxt_s     = yoff_r;
          last_nxt_s  = at_last_s;
          valid_nxt_s = 1'b1;
          // The final address is left in place rather than wrapping past the image.
          if (at_last_s) begin
            state_nxt_s = ST_FLUSH;
          end else if (xoff_r == X_MAX) begin
            xoff_nxt_s = A_ZERO;
            yoff_nxt_s = yoff_r + A_ONE;
          end else begin
            xoff_nxt_s = xoff_r + A_ONE;
          end
        end else begin
          state_nxt_s = ST_SCAN;
        end
      end
      ST_FLUSH: begin
        if (pix.pix_ready) begin
          valid_nxt_s = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_DONE: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address, stream and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      xoff_r  <= A_ZERO;
      yoff_r  <= A_ZERO;
      msel_r  <= 3'd0;
      valid_r <= 1'b0;
      data_r  <= 1'b0;
      x_r     <= A_ZERO;
      y_r     <= A_ZERO;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      xoff_r  <= xoff_nxt_s;
      yoff_r  <= yoff_nxt_s;
      msel_r  <= msel_nxt_s;
      valid_r <= valid_nxt_s;
      data_r  <= data_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      last_r  <= last_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign xoff          = xoff_r;
  assign yoff          = yoff_r;
  assign memorySelect  = msel_r;
  assign pix.pix_valid = valid_r;
  assign pix.pix_data  = data_r;
  assign pix.pix_x     = x_r;
  assign pix.pix_y     = y_r;
  assign pix.pix_last  = last_r;
  assign busy          = busy_r;
  assign done          = done_r;

`ifdef PIXEL_COUNT_EN
  logic [2*ADDR_W:0] ones_r, ones_nxt_s;
  logic              start_acc_s;

  assign start_acc_s = (state_r == ST_IDLE) && start;

  // Ones counter: restarts on each accepted start, holds once the scan is over.
  always_comb begin
    ones_nxt_s = ones_r;
    if (start_acc_s) begin
      ones_nxt_s = {(2*ADDR_W+1){1'b0}};
    end else if (accept_s && data_r) begin
      ones_nxt_s = ones_r + {{(2*ADDR_W){1'b0}}, 1'b1};
    end else begin
      ones_nxt_s = ones_r;
    end
  end

  // Ones counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ones_r <= {(2*ADDR_W+1){1'b0}};
    end else begin
      ones_r <= ones_nxt_s;
    end
  end

  assign ones_count = ones_r;
`else
  logic unused_accept_s;
  assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_rom_raster_scanner.sv
// Randomized self-checking bench for rom_raster_scanner on a 4x2 image whose
// ROM returns xoff[0]^yoff[0]; expected beats come from a row-major image model.
`timescale 1ns/1ps
module tb_rom_raster_scanner;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 8;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        img_sel = 3'd0;
  logic [ADDR_W-1:0] xoff, yoff;
  logic [2:0]        memorySelect;
  logic              pixel;
  logic              busy, done;
`ifdef PIXEL_COUNT_EN
  logic [2*ADDR_W:0] ones_count;
  int                ones_after_start;
`endif

  rom_raster_scanner_if #(.ADDR_W(ADDR_W)) pix ();

  rom_raster_scanner #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .img_sel      (img_sel),
    .xoff         (xoff),
    .yoff         (yoff),
    .memorySelect (memorySelect),
    .pixel        (pixel),
    .pix          (pix.master),
    .busy         (busy),
    .done         (done)
`ifdef PIXEL_COUNT_EN
    ,
    .ones_count   (ones_count)
`endif
  );

  always #5 clk = ~clk;

  // ROM model
  assign pixel = xoff[0] ^ yoff[0];

  int n_pass = 0;
  int n_total = 0;

  int got_x[$], got_y[$], got_d[$], got_l[$];
  int done_cnt, done_idx, last_acc_idx, first_valid_idx;
  int stall_viol, memsel_bad, busy_bad, stall_cycles, busy_after_done;
  int stall_x, stall_y;
  bit timed_out;

  // Image model: beat k is pixel (k%W, k/W), value parity of x+y.
  function automatic int exp_x(int k); return k % IMG_W; endfunction
  function automatic int exp_y(int k); return k / IMG_W; endfunction
  function automatic int exp_d(int k); return (exp_x(k) + exp_y(k)) % 2; endfunction
  function automatic int exp_l(int k); return (k == NPIX - 1) ? 1 : 0; endfunction
  function automatic int exp_ones();
    int s = 0;
    for (int k = 0; k < NPIX; k++) s += exp_d(k);
    return s;
  endfunction

  // Stimulus driver: runs one scan, records beats and protocol observations.
  // mode 0: ready high, 1: random ready, 2: 3-cycle stall when beat 3 is offered.
  task automatic run_scan(input logic [2:0] sel, input int mode, input bit disturb);
    bit               prev_stall = 1'b0;
    bit               finished = 1'b0;
    logic [ADDR_W-1:0] sx, sy, sxo, syo;
    logic             sd, sl;
    got_x.delete(); got_y.delete(); got_d.delete(); got_l.delete();
    done_cnt = 0; done_idx = -1; last_acc_idx = -1; first_valid_idx = -1;
    stall_viol = 0; memsel_bad = 0; busy_bad = 0; stall_cycles = 0;
    busy_after_done = -1; stall_x = -1; stall_y = -1; timed_out = 1'b0;
    sx = '0; sy = '0; sxo = '0; syo = '0; sd = 1'b0; sl = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc >= 1) begin
        if (prev_stall && (pix.pix_x !== sx || pix.pix_y !== sy || pix.pix_data !== sd ||
            pix.pix_last !== sl || pix.pix_valid !== 1'b1 || xoff !== sxo || yoff !== syo))
          stall_viol++;
        if (pix.pix_valid && first_valid_idx < 0) first_valid_idx = cyc;
        if (done === 1'b1) begin
          done_cnt++;
          if (done_idx < 0) done_idx = cyc;
        end
        if (done_idx >= 0 && cyc == done_idx + 1) busy_after_done = int'(busy);
        if (done_idx < 0 && busy !== 1'b1) busy_bad++;
        if (memorySelect !== sel) memsel_bad++;
`ifdef PIXEL_COUNT_EN
        if (cyc == 1) ones_after_start = int'(ones_count);
`endif
        if (done_idx >= 0 && cyc >= done_idx + 3) begin
          finished = 1'b1;
          break;
        end
      end
      if (cyc == 0) begin
        start = 1'b1;
        img_sel = sel;
      end else if (disturb && busy) begin
        start = ($urandom_range(0, 3) == 0);
        img_sel = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      if (mode == 1) begin
        pix.pix_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2 && pix.pix_valid && got_x.size() == 2 && stall_cycles < 3) begin
        pix.pix_ready = 1'b0;
        stall_cycles++;
        if (stall_x < 0) begin
          stall_x = int'(pix.pix_x);
          stall_y = int'(pix.pix_y);
        end
      end else begin
        pix.pix_ready = 1'b1;
      end
      if (pix.pix_valid && pix.pix_ready) begin
        got_x.push_back(int'(pix.pix_x));
        got_y.push_back(int'(pix.pix_y));
        got_d.push_back(int'(pix.pix_data));
        got_l.push_back(int'(pix.pix_last));
        if (got_x.size() == NPIX) last_acc_idx = cyc;
      end
      prev_stall = pix.pix_valid && !pix.pix_ready;
      sx = pix.pix_x; sy = pix.pix_y; sd = pix.pix_data; sl = pix.pix_last;
      sxo = xoff; syo = yoff;
      @(negedge clk);
    end
    start = 1'b0;
    pix.pix_ready = 1'b1;
    if (!finished) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; pix.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++;
      if ({xoff, yoff, memorySelect, pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y,
           pix.pix_last, busy, done} !== '0)
        $display("FAIL idle_outputs cyc%0d got xoff=%0d yoff=%0d msel=%0d v=%0b x=%0d y=%0d busy=%0b done=%0b required all 0",
                 c, xoff, yoff, memorySelect, pix.pix_valid, pix.pix_x, pix.pix_y, busy, done);
      else n_pass++;
    end
`ifdef PIXEL_COUNT_EN
    n_total++;
    if (ones_count !== '0) $display("FAIL reset_ones got %0d required 0", ones_count);
    else n_pass++;
`endif
  endtask

  task automatic test_full_scan();
    run_scan(3'd5, 0, 1'b0);
    n_total++;
    if (timed_out) $display("FAIL fs_timeout got no done required done"); else n_pass++;
    n_total++;
    if (got_x.size() != NPIX) $display("FAIL fs_count got %0d required %0d", got_x.size(), NPIX);
    else n_pass++;
    for (int k = 0; k < NPIX && k < got_x.size(); k++) begin
      n_total++;
      if (got_x[k] != exp_x(k) || got_y[k] != exp_y(k) || got_d[k] != exp_d(k) || got_l[k] != exp_l(k))
        $display("FAIL fs_beat%0d got (%0d,%0d) d%0d l%0d required (%0d,%0d) d%0d l%0d", k,
                 got_x[k], got_y[k], got_d[k], got_l[k], exp_x(k), exp_y(k), exp_d(k), exp_l(k));
      else n_pass++;
    end
    n_total++;
    if (memsel_bad != 0) $display("FAIL fs_memsel got %0d bad cycles required 0", memsel_bad); else n_pass++;
    n_total++;
    if (first_valid_idx != 2) $display("FAIL fs_latency got %0d required 2", first_valid_idx); else n_pass++;
    n_total++;
    if (done_cnt != 1) $display("FAIL fs_done_count got %0d required 1", done_cnt); else n_pass++;
    n_total++;
    if (done_idx != last_acc_idx + 1)
      $display("FAIL fs_done_timing got %0d required %0d", done_idx, last_acc_idx + 1);
    else n_pass++;
    n_total++;
    if (busy_bad != 0) $display("FAIL fs_busy got %0d low cycles required 0", busy_bad); else n_pass++;
    n_total++;
    if (busy_after_done != 0) $display("FAIL fs_busy_end got %0d required 0", busy_after_done); else n_pass++;
`ifdef PIXEL_COUNT_EN
    n_total++;
    if (int'(ones_count) != exp_ones()) $display("FAIL fs_ones got %0d required %0d", ones_count, exp_ones());
    else n_pass++;
`endif
  endtask

  task automatic test_backpressure();
    run_scan(3'd2, 2, 1'b0);
    n_total++;
    if (timed_out) $display("FAIL bp_timeout got no done required done"); else n_pass++;
    n_total++;
    if (stall_x != 2 || stall_y != 0 || stall_cycles != 3)
      $display("FAIL bp_stall_point got (%0d,%0d) x%0d required (2,0) x3", stall_x, stall_y, stall_cycles);
    else n_pass++;
    n_total++;
    if (stall_viol != 0) $display("FAIL bp_hold got %0d changes required 0", stall_viol); else n_pass++;
    n_total++;
    if (got_x.size() != NPIX) $display("FAIL bp_count got %0d required %0d", got_x.size(), NPIX);
    else n_pass++;
    for (int k = 0; k < NPIX && k < got_x.size(); k++) begin
      n_total++;
      if (got_x[k] != exp_x(k) || got_y[k] != exp_y(k) || got_d[k] != exp_d(k) || got_l[k] != exp_l(k))
        $display("FAIL bp_beat%0d got (%0d,%0d) d%0d l%0d required (%0d,%0d) d%0d l%0d", k,
                 got_x[k], got_y[k], got_d[k], got_l[k], exp_x(k), exp_y(k), exp_d(k), exp_l(k));
      else n_pass++;
    end
    n_total++;
    if (done_cnt != 1 || done_idx != last_acc_idx + 1)
      $display("FAIL bp_done got count %0d at %0d required 1 at %0d", done_cnt, done_idx, last_acc_idx + 1);
    else n_pass++;
  endtask

  task automatic test_random_ready_restart();
    for (int it = 0; it < 3; it++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(0, 7));
      run_scan(sel, 1, 1'b1);
      n_total++;
      if (timed_out) $display("FAIL rr%0d_timeout got no done required done", it); else n_pass++;
      n_total++;
      if (memsel_bad != 0) $display("FAIL rr%0d_memsel got %0d bad cycles required 0", it, memsel_bad);
      else n_pass++;
      n_total++;
      if (stall_viol != 0) $display("FAIL rr%0d_hold got %0d changes required 0", it, stall_viol); else n_pass++;
      n_total++;
      if (got_x.size() != NPIX) $display("FAIL rr%0d_count got %0d required %0d", it, got_x.size(), NPIX);
      else n_pass++;
      for (int k = 0; k < NPIX && k < got_x.size(); k++) begin
        n_total++;
        if (got_x[k] != exp_x(k) || got_y[k] != exp_y(k) || got_d[k] != exp_d(k) || got_l[k] != exp_l(k))
          $display("FAIL rr%0d_beat%0d got (%0d,%0d) d%0d l%0d required (%0d,%0d) d%0d l%0d", it, k,
                   got_x[k], got_y[k], got_d[k], got_l[k], exp_x(k), exp_y(k), exp_d(k), exp_l(k));
        else n_pass++;
      end
      n_total++;
      if (done_cnt != 1 || done_idx != last_acc_idx + 1)
        $display("FAIL rr%0d_done got count %0d at %0d required 1 at %0d", it, done_cnt, done_idx, last_acc_idx + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_scan();
    int acc = 0;
    bit hit = 1'b0;
    bit done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; img_sel = 3'd4; pix.pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (pix.pix_valid) begin
        if (acc == 4) begin
          rst = 1'b0;
          hit = 1'b1;
          break;
        end
        acc++;
      end
      @(negedge clk);
    end
    n_total++;
    if (!hit) $display("FAIL rm_reach_beat5 got %0d beats required 5th offered", acc); else n_pass++;
    n_total++;
    if (pix.pix_x !== 8'd0 || pix.pix_y !== 8'd1)
      $display("FAIL rm_beat5_coord got (%0d,%0d) required (0,1)", pix.pix_x, pix.pix_y);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({xoff, yoff, memorySelect, pix.pix_valid, pix.pix_data, pix.pix_x, pix.pix_y,
         pix.pix_last, busy, done} !== '0)
      $display("FAIL rm_reset_outputs got xoff=%0d yoff=%0d msel=%0d v=%0b busy=%0b done=%0b required all 0",
               xoff, yoff, memorySelect, pix.pix_valid, busy, done);
    else n_pass++;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    n_total++;
    if (done_seen) $display("FAIL rm_no_done got activity after abort required none"); else n_pass++;
    run_scan(3'd3, 0, 1'b0);
    n_total++;
    if (got_x.size() != NPIX || timed_out)
      $display("FAIL rm_restart_count got %0d required %0d", got_x.size(), NPIX);
    else n_pass++;
    for (int k = 0; k < NPIX && k < got_x.size(); k++) begin
      n_total++;
      if (got_x[k] != exp_x(k) || got_y[k] != exp_y(k) || got_d[k] != exp_d(k) || got_l[k] != exp_l(k))
        $display("FAIL rm_beat%0d got (%0d,%0d) d%0d l%0d required (%0d,%0d) d%0d l%0d", k,
                 got_x[k], got_y[k], got_d[k], got_l[k], exp_x(k), exp_y(k), exp_d(k), exp_l(k));
      else n_pass++;
    end
  endtask

`ifdef PIXEL_COUNT_EN
  task automatic test_ones_count();
    run_scan(3'd1, 0, 1'b0);
    n_total++;
    if (int'(ones_count) != exp_ones()) $display("FAIL oc_first got %0d required %0d", ones_count, exp_ones());
    else n_pass++;
    run_scan(3'd7, 1, 1'b0);
    n_total++;
    if (ones_after_start != 0) $display("FAIL oc_clear got %0d required 0", ones_after_start); else n_pass++;
    n_total++;
    if (int'(ones_count) != exp_ones()) $display("FAIL oc_second got %0d required %0d", ones_count, exp_ones());
    else n_pass++;
  endtask
`endif

  initial begin
    pix.pix_ready = 1'b0;
    test_reset();
    test_full_scan();
    test_backpressure();
    test_random_ready_restart();
    test_reset_mid_scan();
`ifdef PIXEL_COUNT_EN
    test_ones_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
